// File: rtl/fob_key_rotator.sv
// Rotating 24-bit one-time key for the fob: a Galois LFSR is scrambled for ROUNDS cycles
// on every rising edge of the 5 s clock, with an epoch count and a 2 ms lifetime countdown.
module fob_key_rotator #(
  parameter int unsigned KEYCHANGE_PERIOD = 5,
  parameter int unsigned ROUNDS           = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        clk_500Hz,
  input  logic        clk_5s,
  input  logic        seed_load,
  input  logic [31:0] seed,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        key_new,
  output logic        busy,
  output logic [15:0] epoch,
  output logic [11:0] time_left
);

  localparam logic [11:0] TL_RELOAD = 12'(KEYCHANGE_PERIOD * 500);
  localparam logic [7:0]  ROUNDS_L  = 8'(ROUNDS);
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // x^32 + x^22 + x^2 + x + 1, Galois form, shifting right
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_SCRAMBLE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_lfsr;
  logic [7:0]  r_rcnt;
  logic [23:0] r_key;
  logic        r_key_valid;
  logic        r_key_new;
  logic        r_busy;
  logic [15:0] r_epoch;
  logic [11:0] r_time_left;
  logic        r_p5;
  logic        r_p500;

  logic        w_rise5;
  logic        w_rise500;
  logic        w_last_step;
  logic [31:0] w_lfsr_next;

  assign w_rise5     = clk_5s & ~r_p5;
  assign w_rise500   = clk_500Hz & ~r_p500;
  assign w_last_step = (r_state == ST_SCRAMBLE) && (r_rcnt == 8'd1);
  assign w_lfsr_next = lfsr_step(r_lfsr);

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNSEEDED;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a seed load overrides everything, including a pending rise5.
  always_comb begin
    w_next = r_state;
    if (seed_load) begin
      w_next = ST_SCRAMBLE;
    end else begin
      case (r_state)
        ST_UNSEEDED: w_next = ST_UNSEEDED;
        ST_IDLE:     w_next = w_rise5 ? ST_SCRAMBLE : ST_IDLE;
        ST_SCRAMBLE: w_next = (r_rcnt == 8'd1) ? ST_IDLE : ST_SCRAMBLE;
        default:     w_next = ST_UNSEEDED;
      endcase
    end
  end

  // Edge detectors, LFSR/round counter, key, epoch and busy.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_p5        <= 1'b0;
      r_p500      <= 1'b0;
      r_lfsr      <= 32'h0000_0001;
      r_rcnt      <= 8'd0;
      r_key       <= 24'd0;
      r_key_valid <= 1'b0;
      r_key_new   <= 1'b0;
      r_busy      <= 1'b0;
      r_epoch     <= 16'd0;
    end else begin
      r_p5      <= clk_5s;
      r_p500    <= clk_500Hz;
      r_key_new <= 1'b0;
      r_busy    <= (w_next == ST_SCRAMBLE);
      if (seed_load) begin
        r_lfsr      <= (seed == 32'd0) ? 32'h0000_0001 : seed;
        r_rcnt      <= ROUNDS_L;
        r_key       <= 24'd0;
        r_key_valid <= 1'b0;
        r_epoch     <= 16'd0;
      end else if (r_state == ST_SCRAMBLE) begin
        r_lfsr <= w_lfsr_next;
        r_rcnt <= r_rcnt - 8'd1;
        if (r_rcnt == 8'd1) begin
          r_key       <= w_lfsr_next[31:8];
          r_key_valid <= 1'b1;
          r_key_new   <= 1'b1;
          r_epoch     <= r_epoch + 16'd1;
        end else begin
          r_key_valid <= r_key_valid;
        end
      end else if ((r_state == ST_IDLE) && w_rise5) begin
        r_rcnt <= ROUNDS_L;
      end else begin
        r_rcnt <= r_rcnt;
      end
    end
  end

  // Lifetime countdown: seed clear beats reload, reload beats a 2 ms tick.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_time_left <= 12'd0;
    end else if (seed_load) begin
      r_time_left <= 12'd0;
    end else if (w_last_step) begin
      r_time_left <= TL_RELOAD;
    end else if (w_rise500 && (r_time_left != 12'd0)) begin
      r_time_left <= r_time_left - 12'd1;
    end else begin
      r_time_left <= r_time_left;
    end
  end

  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_new   = r_key_new;
  assign busy      = r_busy;
  assign epoch     = r_epoch;
  assign time_left = r_time_left;

endmodule

// File: tb/tb_fob_key_rotator.sv
// Randomised scoreboard bench for fob_key_rotator: stimulus tasks push expected keys,
// a negedge monitor pops them on key_new and tracks time_left against a reference model.
`timescale 1ns/1ps
module tb_fob_key_rotator;

  localparam int          ROUNDS = 8;
  localparam int          KCP    = 5;
  localparam logic [11:0] RELOAD = 12'd2500;

  logic        sys_clk   = 1'b0;
  logic        rst       = 1'b1;
  logic        clk_500Hz = 1'b0;
  logic        clk_5s    = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed      = 32'd0;
  logic [23:0] key;
  logic        key_valid;
  logic        key_new;
  logic        busy;
  logic [15:0] epoch;
  logic [11:0] time_left;

  typedef struct {
    logic [23:0] key;
    logic [15:0] epoch;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          nchecks   = 0;
  int          nerr      = 0;
  int          cyc       = 0;
  int          m_end_cyc = -1;
  logic [31:0] m_lfsr    = 32'd1;
  logic [15:0] m_epoch   = 16'd0;
  logic [11:0] m_tl;
  logic        m_p500;
  bit          fast      = 1'b0;
  bit          run_bg    = 1'b1;

  fob_key_rotator #(.KEYCHANGE_PERIOD(KCP), .ROUNDS(ROUNDS)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .clk_500Hz (clk_500Hz),
    .clk_5s    (clk_5s),
    .seed_load (seed_load),
    .seed      (seed),
    .key       (key),
    .key_valid (key_valid),
    .key_new   (key_new),
    .busy      (busy),
    .epoch     (epoch),
    .time_left (time_left)
  );

  always #500 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference key polynomial: halve the state, folding the polynomial in when it was odd.
  function automatic logic [31:0] advance(input logic [31:0] s, input int n);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < n; i++) begin
      x = (x % 2 == 1) ? ((x / 2) ^ 32'h8020_0003) : (x / 2);
    end
    return x;
  endfunction

  // Lifetime model: cleared by a load, reloaded when a key lands, else one tick per 2 ms edge.
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_tl   <= 12'd0;
      m_p500 <= 1'b0;
    end else begin
      m_p500 <= clk_500Hz;
      if (seed_load) m_tl <= 12'd0;
      else if (cyc + 1 == m_end_cyc) m_tl <= RELOAD;
      else if (clk_500Hz && !m_p500 && m_tl != 12'd0) m_tl <= m_tl - 12'd1;
    end
  end

  // Monitor: compare countdown every cycle, pop an expectation on each key_new.
  exp_t e_mon;
  always @(negedge sys_clk) begin
    if (!rst) begin
      chk("time_left", {20'd0, time_left}, {20'd0, m_tl});
      if (key_new) begin
        if (q.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_key_new: key=%h epoch=%0d, expected no key (cycle %0d)", key, epoch, cyc);
        end else begin
          e_mon = q.pop_front();
          chk("key", {8'd0, key}, {8'd0, e_mon.key});
          chk("epoch", {16'd0, epoch}, {16'd0, e_mon.epoch});
          chk("key_cycle", cyc, e_mon.cyc);
          chk("key_valid", {31'd0, key_valid}, 32'd1);
          chk("reload", {20'd0, time_left}, {20'd0, RELOAD});
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        nchecks++;
        nerr++;
        $display("FAIL key_timeout: got no key_new, expected key %h at cycle %0d", q[0].key, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // 2 ms source: either toggles every cycle or wanders randomly.
  initial begin
    while (run_bg) begin
      @(negedge sys_clk);
      if (fast) clk_500Hz = ~clk_500Hz;
      else if ($urandom_range(0, 5) == 0) clk_500Hz = ~clk_500Hz;
    end
  end

  task automatic do_seed(input logic [31:0] s, input bit wait_done);
    exp_t e;
    @(negedge sys_clk);
    if (q.size() > 0) void'(q.pop_back());
    seed_load = 1'b1;
    seed      = s;
    m_lfsr    = advance((s == 32'd0) ? 32'd1 : s, ROUNDS);
    m_epoch   = 16'd1;
    e.key     = m_lfsr[31:8];
    e.epoch   = m_epoch;
    e.cyc     = cyc + 1 + ROUNDS;
    q.push_back(e);
    m_end_cyc = e.cyc;
    @(negedge sys_clk);
    seed_load = 1'b0;
    seed      = $urandom;
    chk("load_key", {8'd0, key}, 32'd0);
    chk("load_key_valid", {31'd0, key_valid}, 32'd0);
    chk("load_epoch", {16'd0, epoch}, 32'd0);
    chk("load_busy", {31'd0, busy}, 32'd1);
    if (wait_done) repeat (ROUNDS + 2) @(negedge sys_clk);
  endtask

  task automatic trigger_key(input bit glitch);
    exp_t e;
    int   h;
    int   n;
    int   bc;
    @(negedge sys_clk);
    clk_5s    = 1'b1;
    m_lfsr    = advance(m_lfsr, ROUNDS);
    m_epoch   = m_epoch + 16'd1;
    e.key     = m_lfsr[31:8];
    e.epoch   = m_epoch;
    e.cyc     = cyc + 1 + ROUNDS;
    q.push_back(e);
    m_end_cyc = e.cyc;
    h  = glitch ? 1 : int'($urandom_range(1, 30));
    n  = ((h > ROUNDS) ? h : ROUNDS) + 3;
    bc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (busy) bc++;
      if (i + 1 == h) clk_5s = 1'b0;
      if (glitch && i == 2) clk_5s = 1'b1;
      if (glitch && i == 4) clk_5s = 1'b0;
    end
    chk("busy_cycles", bc, ROUNDS);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_key"}, {8'd0, key}, 32'd0);
    chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_key_new"}, {31'd0, key_new}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_epoch"}, {16'd0, epoch}, 32'd0);
    chk({tag, "_time_left"}, {20'd0, time_left}, 32'd0);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Unseeded: clk_5s activity must not produce any key.
    @(negedge sys_clk);
    clk_5s = 1'b1;
    repeat (1000) @(negedge sys_clk);
    clk_5s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      clk_5s = ~clk_5s;
    end
    repeat (3) @(negedge sys_clk);
    check_all_zero("unseeded");

    do_seed(32'd1, 1'b1);
    do_seed(32'd0, 1'b1);
    for (int i = 0; i < 12; i++) trigger_key($urandom_range(0, 3) == 0);

    // Countdown to zero and hold.
    trigger_key(1'b0);
    fast = 1'b1;
    repeat (5200) @(negedge sys_clk);
    chk("time_left_floor", {20'd0, time_left}, 32'd0);

    // Reloads at both 2 ms phases.
    do_seed($urandom, 1'b1);
    @(negedge sys_clk);
    do_seed($urandom, 1'b1);
    trigger_key(1'b0);
    @(negedge sys_clk);
    trigger_key(1'b0);
    fast = 1'b0;

    // Restart during the fourth scramble cycle.
    do_seed(32'hDEAD_BEEF, 1'b0);
    repeat (2) @(negedge sys_clk);
    do_seed(32'h1234_5678, 1'b1);
    chk("restart_epoch", {16'd0, epoch}, 32'd1);
    trigger_key(1'b0);

    // Asynchronous reset mid-scramble.
    do_seed($urandom, 1'b0);
    repeat (2) @(negedge sys_clk);
    #100;
    rst = 1'b1;
    q.delete();
    m_end_cyc = -1;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (ROUNDS + 2) @(negedge sys_clk);
    check_all_zero("post_rst");

    do_seed($urandom, 1'b1);
    trigger_key(1'b1);
    trigger_key(1'b0);
    repeat (5) @(negedge sys_clk);
    chk("queue_drained", q.size(), 0);

    run_bg = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
